// File: rtl/piso_tx_pkg.sv
// Shared types and line-level constants for the framed PISO transmitter.
// The width helper sizes counters so that a count of one still gets a one-bit register.
package piso_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bit_tick_counter.sv
// Bit-period timer: TICK marks the last clock of each BIT_CYCLES-long bit.
// Held at zero while EN is low, so every frame starts with a full-length bit.
module bit_tick_counter
  import piso_tx_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic CLK,
  input  logic CLR,
  input  logic EN,
  output logic TICK
);

  localparam int unsigned     CW   = cnt_width(BIT_CYCLES);
  localparam logic [CW-1:0]   LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign TICK = EN && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (!EN || TICK) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/piso_serial_tx.sv
// Framed parallel-in/serial-out transmitter: start bit, WIDTH data bits LSB first, stop bit.
// Every output comes straight from a register; CLR aborts any frame without a DONE pulse.
module piso_serial_tx
  import piso_tx_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] DIN,
  input  logic             LOAD,
  output logic             READY,
  output logic             SOUT,
  output logic             BUSY,
  output logic             DONE
);

  localparam int unsigned   IW       = cnt_width(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  tx_state_t        state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             sout_q, sout_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick;

  bit_tick_counter #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_tick (
    .CLK (CLK),
    .CLR (CLR),
    .EN  (state_q != IDLE),
    .TICK(tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    sout_d  = sout_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (LOAD && ready_q) begin
          state_d = START;
          shift_d = DIN;
          idx_d   = '0;
          sout_d  = START_BIT;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          sout_d  = shift_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_q == LAST_IDX) begin
            state_d = STOP;
            sout_d  = STOP_BIT;
          end else begin
            // Shift first so the next LSB is always at bit 0, which also holds for WIDTH=1.
            idx_d   = idx_q + IW'(1);
            shift_d = shift_q >> 1;
            sout_d  = shift_d[0];
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          sout_d  = LINE_IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      sout_q  <= LINE_IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      sout_q  <= sout_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign READY = ready_q;
  assign SOUT  = sout_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_piso_serial_tx.sv
// Directed bench for piso_serial_tx: default 8-bit/4-cycle instance plus a 1-bit/1-cycle corner instance.
// Outputs are sampled 1 ns after each rising edge; inputs change at the same point.
module tb_piso_serial_tx;

  logic       clk = 1'b0;
  logic       clr, load;
  logic [7:0] din;
  logic       ready, sout, busy, done;

  logic       clr2, load2;
  logic [0:0] din2;
  logic       ready2, sout2, busy2, done2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_done = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  piso_serial_tx #(.WIDTH(8), .BIT_CYCLES(4)) dut (
    .CLK(clk), .CLR(clr), .DIN(din), .LOAD(load),
    .READY(ready), .SOUT(sout), .BUSY(busy), .DONE(done)
  );

  piso_serial_tx #(.WIDTH(1), .BIT_CYCLES(1)) dut_c (
    .CLK(clk), .CLR(clr2), .DIN(din2), .LOAD(load2),
    .READY(ready2), .SOUT(sout2), .BUSY(busy2), .DONE(done2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected line level c cycles after accept for an 8-bit, 4-cycle frame.
  function automatic logic frame_bit(input logic [7:0] d, input int c);
    int j;
    j = c / 4;
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return d[j-1];
  endfunction

  // Entered just after accept edge E0; leaves just after E0+40 (the DONE cycle).
  task automatic check_frame(input logic [7:0] d, input string nm, input int inject_at);
    logic eb;
    for (int c = 0; c <= 40; c++) begin
      if (c < 40) begin
        eb = frame_bit(d, c);
        checks++;
        if (sout !== eb || busy !== 1'b1 || ready !== 1'b0 || done !== 1'b0) begin
          errors++;
          $display("FAIL %s c=%0d got sout=%b busy=%b ready=%b done=%b want sout=%b busy=1 ready=0 done=0",
                   nm, c, sout, busy, ready, done, eb);
        end
      end else begin
        checks++;
        if (sout !== 1'b1 || busy !== 1'b0 || ready !== 1'b1 || done !== 1'b1) begin
          errors++;
          $display("FAIL %s_end got sout=%b busy=%b ready=%b done=%b want sout=1 busy=0 ready=1 done=1",
                   nm, sout, busy, ready, done);
        end
        last_done = cyc;
      end
      if (inject_at >= 0 && c == inject_at) begin
        din  = 8'hFF;
        load = 1'b1;
      end
      if (inject_at >= 0 && c == inject_at + 3) load = 1'b0;
      if (c < 40) step();
    end
  endtask

  task automatic check_idle(input string nm, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      checks++;
      if (sout !== 1'b1 || busy !== 1'b0 || ready !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s i=%0d got sout=%b busy=%b ready=%b done=%b want sout=1 busy=0 ready=1 done=0",
                 nm, i, sout, busy, ready, done);
      end
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    load = 1'b0;
    din = 8'h00;
    step();
    step();
    clr = 1'b0;
    checks++;
    if (sout !== 1'b1 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset got sout=%b ready=%b busy=%b done=%b want 1 1 0 0", sout, ready, busy, done);
    end
    check_idle("reset_stable", 20);
  endtask

  task automatic test_single_frame();
    din = 8'hA5;
    load = 1'b1;
    step();
    load = 1'b0;
    check_frame(8'hA5, "frame_a5", -1);
    check_idle("after_a5", 2);
  endtask

  task automatic test_ignored_load();
    din = 8'h3C;
    load = 1'b1;
    step();
    load = 1'b0;
    check_frame(8'h3C, "ignored_load", 10);
    check_idle("no_second_frame", 8);
  endtask

  task automatic test_back_to_back();
    int d1;
    din = 8'h01;
    load = 1'b1;
    step();
    din = 8'h80;
    check_frame(8'h01, "b2b_first", -1);
    d1 = last_done;
    step();
    load = 1'b0;
    check_frame(8'h80, "b2b_second", -1);
    checks++;
    if (last_done - d1 !== 41) begin
      errors++;
      $display("FAIL b2b_done_gap got %0d want 41", last_done - d1);
    end
    check_idle("after_b2b", 2);
  endtask

  task automatic test_abort();
    logic eb;
    din = 8'hC3;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int c = 0; c <= 16; c++) begin
      eb = frame_bit(8'hC3, c);
      checks++;
      if (sout !== eb || busy !== 1'b1) begin
        errors++;
        $display("FAIL abort_pre c=%0d got sout=%b busy=%b want sout=%b busy=1", c, sout, busy, eb);
      end
      if (c == 16) clr = 1'b1;
      step();
    end
    clr = 1'b0;
    checks++;
    if (sout !== 1'b1 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_edge got sout=%b ready=%b busy=%b done=%b want 1 1 0 0", sout, ready, busy, done);
    end
    check_idle("abort_no_done", 30);
    din = 8'h55;
    load = 1'b1;
    step();
    load = 1'b0;
    check_frame(8'h55, "after_abort_55", -1);
  endtask

  task automatic test_corner();
    logic [3:0] exp_sout, exp_busy, exp_done;
    clr2 = 1'b1;
    load2 = 1'b0;
    step();
    clr2 = 1'b0;
    din2 = 1'b1;
    load2 = 1'b1;
    step();
    load2 = 1'b0;
    // cycles E0, E0+1, E0+2, E0+3 (index 0..3)
    exp_sout = 4'b1110;
    exp_busy = 4'b0111;
    exp_done = 4'b1000;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (sout2 !== exp_sout[c] || busy2 !== exp_busy[c] || done2 !== exp_done[c] || ready2 !== exp_done[c]) begin
        errors++;
        $display("FAIL corner c=%0d got sout=%b busy=%b done=%b ready=%b want sout=%b busy=%b done=%b ready=%b",
                 c, sout2, busy2, done2, ready2, exp_sout[c], exp_busy[c], exp_done[c], exp_done[c]);
      end
      step();
    end
    checks++;
    if (done2 !== 1'b0) begin
      errors++;
      $display("FAIL corner_done_clear got %b want 0", done2);
    end
    clr2 = 1'b1;
    load2 = 1'b1;
    step();
    clr2 = 1'b0;
    load2 = 1'b0;
    checks++;
    if (busy2 !== 1'b0 || ready2 !== 1'b1 || sout2 !== 1'b1 || done2 !== 1'b0) begin
      errors++;
      $display("FAIL corner_clr_load got busy=%b ready=%b sout=%b done=%b want 0 1 1 0", busy2, ready2, sout2, done2);
    end
    step();
    checks++;
    if (busy2 !== 1'b0 || sout2 !== 1'b1) begin
      errors++;
      $display("FAIL corner_no_accept got busy=%b sout=%b want 0 1", busy2, sout2);
    end
  endtask

  initial begin
    clr = 1'b1;
    load = 1'b0;
    din = 8'h00;
    clr2 = 1'b1;
    load2 = 1'b0;
    din2 = 1'b0;
    test_reset();
    test_single_frame();
    test_ignored_load();
    test_back_to_back();
    test_abort();
    test_corner();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
